// File: rtl/robo_pkg.sv
// Shared codes for the cleaning-robot navigation controller: state and heading
// encodings plus the clockwise heading rotation.
`timescale 1ns/1ps
package robo_pkg;

  typedef enum logic [2:0] {
    OCIOSO    = 3'b000,
    AVANCA    = 3'b001,
    LIMPA     = 3'b010,
    GIRA      = 3'b011,
    BLOQUEADO = 3'b100
  } estado_t;

  typedef enum logic [2:0] {
    ORI_NENHUMA = 3'b000,
    ORI_N       = 3'b001,
    ORI_O       = 3'b010,
    ORI_L       = 3'b011,
    ORI_S       = 3'b100
  } orient_t;

  // Last turn count before every heading has been tried.
  localparam logic [1:0] GIROS_MAX = 2'd3;

  // Clockwise: N -> L -> S -> O -> N; an unset heading restarts at N.
  function automatic orient_t gira_horario(input orient_t o);
    orient_t r;
    case (o)
      ORI_N:   r = ORI_L;
      ORI_L:   r = ORI_S;
      ORI_S:   r = ORI_O;
      ORI_O:   r = ORI_N;
      default: r = ORI_N;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/temporizador_limpeza.sv
// Cleaning wait counter: counts enabled cycles from zero and flags the
// terminal count LIMITE-1; clear has priority over enable.
`timescale 1ns/1ps
module temporizador_limpeza #(
  parameter int unsigned LIMITE = 16
) (
  input  logic clockc3,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int unsigned W = (LIMITE > 1) ? $clog2(LIMITE) : 1;
  localparam logic [W-1:0] ULTIMO = W'(LIMITE - 1);
  localparam logic [W-1:0] UM     = W'(1);

  logic [W-1:0] conta_q, conta_d;

  // Next count; saturates at the terminal value.
  always_comb begin
    conta_d = conta_q;
    if (clear) begin
      conta_d = '0;
    end else if (enable && (conta_q != ULTIMO)) begin
      conta_d = conta_q + UM;
    end else begin
      conta_d = conta_q;
    end
  end

  // Count register.
  always_ff @(posedge clockc3 or negedge reset) begin
    if (!reset) begin
      conta_q <= '0;
    end else begin
      conta_q <= conta_d;
    end
  end

  assign terminal = (conta_q == ULTIMO);

endmodule

// File: rtl/controle_navegacao.sv
// Navigation controller: Moore FSM steering the advance unit, turning on walls
// and requesting cleaning on dirt, with blocked/timeout error reporting.
`timescale 1ns/1ps
module controle_navegacao
  import robo_pkg::*;
#(
  parameter int unsigned TIMEOUT_LIMPEZA = 16
) (
  input  logic       clockc3,
  input  logic       reset,
  input  logic       inicio,
  input  logic       fim,
  input  logic       parede,
  input  logic       sujeira,
  input  logic       limpeza_ok,
  output logic       avancar,
  output logic [0:2] orientacao,
  output logic       limpar,
  output logic       erro,
  output logic [0:2] estado,
  output logic [7:0] passos
);

  estado_t    estado_q, estado_d;
  orient_t    orient_q, orient_d;
  logic [7:0] passos_q, passos_d;
  logic [1:0] giros_q, giros_d;
  logic       erro_q, erro_d;
  logic       avancar_q, avancar_d;
  logic       limpar_q, limpar_d;
  logic       fim_espera_s;

  temporizador_limpeza #(
    .LIMITE (TIMEOUT_LIMPEZA)
  ) u_temporizador (
    .clockc3  (clockc3),
    .reset    (reset),
    .clear    (estado_q != LIMPA),
    .enable   (estado_q == LIMPA),
    .terminal (fim_espera_s)
  );

  // Next state and register updates; priority is fim > sujeira > parede > advance.
  always_comb begin
    estado_d = estado_q;
    orient_d = orient_q;
    passos_d = passos_q;
    giros_d  = giros_q;
    erro_d   = erro_q;
    case (estado_q)
      OCIOSO: begin
        if (fim) begin
          estado_d = OCIOSO;
        end else if (inicio) begin
          estado_d = AVANCA;
          orient_d = ORI_N;
          passos_d = 8'd0;
          erro_d   = 1'b0;
        end else begin
          estado_d = OCIOSO;
        end
      end
      AVANCA: begin
        if (fim) begin
          estado_d = OCIOSO;
        end else if (sujeira) begin
          estado_d = LIMPA;
        end else if (parede) begin
          estado_d = GIRA;
          orient_d = gira_horario(orient_q);
          giros_d  = 2'd1;
        end else begin
          passos_d = passos_q + 8'd1;
        end
      end
      LIMPA: begin
        if (fim) begin
          estado_d = OCIOSO;
        end else if (limpeza_ok) begin
          estado_d = AVANCA;
        end else if (fim_espera_s) begin
          estado_d = BLOQUEADO;
          erro_d   = 1'b1;
        end else begin
          estado_d = LIMPA;
        end
      end
      GIRA: begin
        if (fim) begin
          estado_d = OCIOSO;
        end else if (sujeira) begin
          estado_d = LIMPA;
          giros_d  = 2'd0;
        end else if (parede) begin
          if (giros_q == GIROS_MAX) begin
            estado_d = BLOQUEADO;
            erro_d   = 1'b1;
          end else begin
            orient_d = gira_horario(orient_q);
            giros_d  = giros_q + 2'd1;
          end
        end else begin
          estado_d = AVANCA;
          giros_d  = 2'd0;
        end
      end
      BLOQUEADO: begin
        if (fim || inicio) begin
          estado_d = OCIOSO;
        end else begin
          estado_d = BLOQUEADO;
        end
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
    // Drive strobes follow the state being entered so they are flop outputs.
    avancar_d = (estado_d == AVANCA);
    limpar_d  = (estado_d == LIMPA);
  end

  // State and output registers.
  always_ff @(posedge clockc3 or negedge reset) begin
    if (!reset) begin
      estado_q  <= OCIOSO;
      orient_q  <= ORI_NENHUMA;
      passos_q  <= 8'd0;
      giros_q   <= 2'd0;
      erro_q    <= 1'b0;
      avancar_q <= 1'b0;
      limpar_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      orient_q  <= orient_d;
      passos_q  <= passos_d;
      giros_q   <= giros_d;
      erro_q    <= erro_d;
      avancar_q <= avancar_d;
      limpar_q  <= limpar_d;
    end
  end

  assign avancar    = avancar_q;
  assign orientacao = orient_q;
  assign limpar     = limpar_q;
  assign erro       = erro_q;
  assign estado     = estado_q;
  assign passos     = passos_q;

endmodule

// File: tb/tb_controle_navegacao.sv
// Self-checking bench for controle_navegacao: directed scenarios followed by
// randomized stimulus, all compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_controle_navegacao;

  localparam int T = 16;
  localparam int S_OC = 0, S_AV = 1, S_LI = 2, S_GI = 3, S_BL = 4;

  logic       clockc3;
  logic       reset, inicio, fim, parede, sujeira, limpeza_ok;
  logic       avancar, limpar, erro;
  logic [0:2] orientacao, estado;
  logic [7:0] passos;

  controle_navegacao #(.TIMEOUT_LIMPEZA(T)) dut (
    .clockc3    (clockc3),
    .reset      (reset),
    .inicio     (inicio),
    .fim        (fim),
    .parede     (parede),
    .sujeira    (sujeira),
    .limpeza_ok (limpeza_ok),
    .avancar    (avancar),
    .orientacao (orientacao),
    .limpar     (limpar),
    .erro       (erro),
    .estado     (estado),
    .passos     (passos)
  );

  initial clockc3 = 1'b0;
  always #5 clockc3 = ~clockc3;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state, in plain integers.
  int m_st, m_or, m_passos, m_giros, m_wait, m_erro;
  int cw [4] = '{1, 3, 4, 2};  // N, L, S, O in clockwise order

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic int rot(input int o);
    for (int i = 0; i < 4; i++) if (cw[i] == o) return cw[(i + 1) % 4];
    return 1;
  endfunction

  task automatic model_reset();
    m_st = S_OC; m_or = 0; m_passos = 0; m_giros = 0; m_wait = 0; m_erro = 0;
  endtask

  task automatic model_step();
    case (m_st)
      S_OC: if (!fim && inicio) begin
        m_st = S_AV; m_or = 1; m_passos = 0; m_erro = 0;
      end
      S_AV: begin
        if (fim) m_st = S_OC;
        else if (sujeira) begin m_st = S_LI; m_wait = 0; end
        else if (parede) begin m_st = S_GI; m_or = rot(m_or); m_giros = 1; end
        else m_passos = (m_passos + 1) % 256;
      end
      S_LI: begin
        if (fim) m_st = S_OC;
        else if (limpeza_ok) m_st = S_AV;
        else if (m_wait == T - 1) begin m_st = S_BL; m_erro = 1; end
        else m_wait = m_wait + 1;
      end
      S_GI: begin
        if (fim) m_st = S_OC;
        else if (sujeira) begin m_st = S_LI; m_wait = 0; m_giros = 0; end
        else if (parede) begin
          if (m_giros < 3) begin m_or = rot(m_or); m_giros++; end
          else begin m_st = S_BL; m_erro = 1; end
        end else begin m_st = S_AV; m_giros = 0; end
      end
      default: if (fim || inicio) m_st = S_OC;
    endcase
  endtask

  task automatic compare_all(input string ctx);
    chk({ctx, "/estado"}, int'(estado), m_st);
    chk({ctx, "/avancar"}, int'(avancar), (m_st == S_AV) ? 1 : 0);
    chk({ctx, "/limpar"}, int'(limpar), (m_st == S_LI) ? 1 : 0);
    chk({ctx, "/orientacao"}, int'(orientacao), m_or);
    chk({ctx, "/erro"}, int'(erro), m_erro);
    chk({ctx, "/passos"}, int'(passos), m_passos);
  endtask

  task automatic drive(input logic i, input logic f, input logic p, input logic s, input logic o);
    inicio = i; fim = f; parede = p; sujeira = s; limpeza_ok = o;
  endtask

  task automatic step();
    @(posedge clockc3);
    model_step();
    #1;
    compare_all("ciclo");
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_all("reset");
    #3 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #1 compare_all("reset_inicial");
    #11 reset = 1'b1;

    // Start and long advance with passos wrap
    drive(1, 0, 0, 0, 0); step();
    chk("inicio_estado", int'(estado), 1);
    chk("inicio_orient", int'(orientacao), 1);
    drive(0, 0, 0, 0, 0);
    repeat (300) step();
    chk("passos_300", int'(passos), 44);

    // Two turns then resume
    drive(0, 0, 1, 0, 0); step(); step();
    drive(0, 0, 0, 0, 0); step();
    chk("giro2_estado", int'(estado), 1);
    chk("giro2_orient", int'(orientacao), 4);

    // Boxed in: all four headings blocked
    do_reset();
    drive(1, 0, 0, 0, 0); step();
    drive(0, 0, 1, 0, 0); repeat (4) step();
    chk("bloq_estado", int'(estado), 4);
    chk("bloq_erro", int'(erro), 1);
    chk("bloq_orient", int'(orientacao), 2);

    // Dirt and wall together, acknowledged cleaning, then the turn
    drive(0, 1, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0); step();
    chk("restart_erro", int'(erro), 0);
    drive(0, 0, 1, 1, 0); step();
    chk("limpa_limpar", int'(limpar), 1);
    drive(0, 0, 1, 0, 0); repeat (4) step();
    drive(0, 0, 1, 0, 1); step();
    chk("limpa_ok_estado", int'(estado), 1);
    drive(0, 0, 1, 0, 0); step();
    chk("pos_limpa_gira", int'(estado), 3);
    drive(0, 0, 0, 0, 0); step();

    // Cleaning timeout, then acknowledge on the last waiting cycle
    drive(0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0); repeat (T - 1) step();
    chk("timeout_ainda_limpa", int'(estado), 2);
    step();
    chk("timeout_estado", int'(estado), 4);
    chk("timeout_erro", int'(erro), 1);
    drive(1, 0, 0, 0, 0); step(); step();
    drive(0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0); repeat (T - 1) step();
    drive(0, 0, 0, 0, 1); step();
    chk("ok_no_limite_estado", int'(estado), 1);
    chk("ok_no_limite_erro", int'(erro), 0);

    // Stop during a turn; reset during cleaning
    drive(0, 0, 1, 0, 0); step();
    drive(0, 1, 0, 0, 0); step();
    chk("fim_gira_estado", int'(estado), 0);
    drive(1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0); step();
    do_reset();
    chk("reset_limpa_limpar", int'(limpar), 0);
    step();
    chk("reset_sem_pendencia", int'(estado), 0);

    // Randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 4000; n++) begin
      drive(logic'($urandom_range(0, 99) < 15), logic'($urandom_range(0, 99) < 3),
            logic'($urandom_range(0, 99) < 35), logic'($urandom_range(0, 99) < 8),
            logic'($urandom_range(0, 99) < 15));
      if ($urandom_range(0, 199) == 0) do_reset();
      else step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/controle_navegacao.md
CONTROLE_NAVEGACAO -- requirements
Module: controle_navegacao

Interface
REQ-001 Parameter: TIMEOUT_LIMPEZA, default 16, max cycles in LIMPA waiting for limpeza_ok.
REQ-002 clockc3  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-004 inicio  input  1  start request; level-sampled.
REQ-005 fim  input  1  stop request; highest priority.
REQ-006 parede  input  1  wall ahead in current orientacao.
REQ-007 sujeira  input  1  dirt detected at current position.
REQ-008 limpeza_ok  input  1  cleaning unit acknowledge.
REQ-009 avancar  output  1  drives the advance unit's avancar input.
REQ-010 orientacao  output  [0:2]  heading: 001 N, 010 O, 011 L, 100 S, 000 none.
REQ-011 limpar  output  1  cleaning request; held until acknowledged.
REQ-012 erro  output  1  blocked or cleaning-timeout flag.
REQ-013 estado  output  [0:2]  current state code, for debug.
REQ-014 passos  output  [7:0]  advance-cycle count.

Function
REQ-015 All outputs SHALL be registered and depend only on the current state and registers (Moore).
REQ-016 States SHALL be OCIOSO 000, AVANCA 001, LIMPA 010, GIRA 011, BLOQUEADO 100.
REQ-017 Priority in every state SHALL be fim > sujeira > parede > advance.
REQ-018 fim=1 in any non-OCIOSO state SHALL go to OCIOSO next edge with avancar=0, limpar=0 and orientacao held.
REQ-019 OCIOSO: inicio=1 SHALL go to AVANCA, set orientacao=001 and clear passos and erro.
REQ-020 AVANCA SHALL drive avancar=1 and increment passos each cycle it stays in AVANCA; passos wraps 255->0.
REQ-021 AVANCA with sujeira=1 SHALL go to LIMPA; passos is not incremented that cycle.
REQ-022 AVANCA with sujeira=0, parede=1 SHALL go to GIRA, rotate orientacao clockwise, and set giros=1.
REQ-023 Clockwise rotation SHALL be N->L->S->O->N (001->011->100->010->001).
REQ-024 GIRA with parede=0 SHALL go to AVANCA and clear giros; orientacao held.
REQ-025 GIRA with parede=1 and giros<3 SHALL rotate again and increment giros.
REQ-026 GIRA with parede=1 and giros=3 SHALL go to BLOQUEADO with erro=1, since all four headings are blocked.
REQ-027 LIMPA SHALL drive limpar=1 and avancar=0 and count wait cycles from 0.
REQ-028 LIMPA with limpeza_ok=1 SHALL go to AVANCA with limpar=0 on the next cycle; sujeira is re-evaluated from AVANCA.
REQ-029 LIMPA with the wait count reaching TIMEOUT_LIMPEZA-1 and no limpeza_ok SHALL go to BLOQUEADO with erro=1.
REQ-030 limpeza_ok arriving in the same cycle as the timeout SHALL take precedence, giving AVANCA with no error.
REQ-031 limpeza_ok outside LIMPA SHALL be ignored.
REQ-032 BLOQUEADO SHALL hold avancar=0, limpar=0 and erro=1; inicio=1 or fim=1 SHALL go to OCIOSO, and erro clears on the next start.
REQ-033 inicio outside OCIOSO and BLOQUEADO SHALL be ignored.

Reset
REQ-034 reset=0 SHALL asynchronously force OCIOSO, avancar=0, orientacao=000, limpar=0, erro=0, passos=0, giros=0 and the wait count to 0.
REQ-035 Reset asserted mid-LIMPA or mid-GIRA SHALL abandon the operation with no pending request retained.
REQ-036 After reset deassertion, the first transition SHALL occur no earlier than the next rising clockc3 edge.

Structure
REQ-037 Orientation codes, state codes and the clockwise rotation function SHALL live in a shared package, robo_pkg.
REQ-038 The cleaning wait counter SHALL be one sub-module, temporizador_limpeza, with inputs clear and enable and a terminal-count output.
REQ-039 The block SHALL drive, but not instantiate, the advance unit.

Verification
REQ-040 Reset low, then inicio=1 for one cycle -> next edge: estado=001, avancar=1, orientacao=001; after 300 AVANCA cycles passos=44 (wrapped).
REQ-041 In AVANCA, orientacao=001, hold parede=1 for 2 GIRA cycles then 0 -> orientacao steps 011, 100, then AVANCA with orientacao=100.
REQ-042 parede held 1 continuously from AVANCA -> headings 011, 100, 010, then BLOQUEADO with erro=1 and avancar=0.
REQ-043 sujeira=1 and parede=1 in the same AVANCA cycle -> LIMPA with limpar=1; limpeza_ok after 5 cycles -> AVANCA, then GIRA.
REQ-044 LIMPA with no limpeza_ok -> BLOQUEADO after 16 cycles; limpeza_ok on the 16th cycle -> AVANCA with erro=0.
REQ-045 fim=1 in GIRA, and reset=0 mid-LIMPA -> OCIOSO next edge (fim) or immediately (reset), with limpar=0 and avancar=0.
